// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: four per-FU result FIFOs merged onto one registered writeback port.
// Define WB_ROUND_ROBIN_EN to replace fixed priority (source 0 first) with a rotating pointer.
module fu_wb_arbiter #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  fin,
   input  logic [31:0] res0,
   input  logic [31:0] res1,
   input  logic [31:0] res2,
   input  logic [31:0] res3,
   input  logic [4:0]  rd0,
   input  logic [4:0]  rd1,
   input  logic [4:0]  rd2,
   input  logic [4:0]  rd3,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [1:0]  wb_src,
   output logic [3:0]  busy,
   output logic        ovf
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t          in_entry [4];
   entry_t          mem_q    [4][FIFO_DEPTH];
   entry_t          head;
   logic [PW-1:0]   wptr_q [4];
   logic [PW-1:0]   wptr_d [4];
   logic [PW-1:0]   rptr_q [4];
   logic [PW-1:0]   rptr_d [4];
   logic [CW-1:0]   cnt_q  [4];
   logic [CW-1:0]   cnt_d  [4];
   logic [3:0]      push;
   logic [3:0]      pop;
   logic [3:0]      accept;
   logic            gnt_valid;
   logic [1:0]      gnt_src;
   logic [1:0]      base;
   logic            ovf_q, ovf_d;
   logic            wb_valid_q;
   logic [4:0]      wb_rd_q;
   logic [31:0]     wb_data_q;
   logic [1:0]      wb_src_q;

   // A zero destination is a non-writing result and never occupies a slot.
   always_comb begin
      in_entry[0] = '{rd: rd0, data: res0};
      in_entry[1] = '{rd: rd1, data: res1};
      in_entry[2] = '{rd: rd2, data: res2};
      in_entry[3] = '{rd: rd3, data: res3};
      for (int i = 0; i < 4; i++) begin
         push[i] = fin[i] && (in_entry[i].rd != 5'd0);
      end
   end

`ifdef WB_ROUND_ROBIN_EN
   logic [1:0] rr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= 2'd0;
      end else if (gnt_valid) begin
         rr_q <= gnt_src + 2'd1;
      end
   end

   assign base = rr_q;
`else
   assign base = 2'd0;
`endif

   // Scan from lowest to highest priority so the highest-priority non-empty source wins last.
   always_comb begin
      logic [1:0] idx;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      gnt_valid = 1'b0;
      gnt_src   = 2'd0;
      idx       = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (cnt_q[idx] != '0) begin
            gnt_valid = 1'b1;
            gnt_src   = idx;
         end
      end
   end

   always_comb begin
      pop    = '0;
      busy   = '0;
      accept = '0;
      if (gnt_valid) begin
         pop[gnt_src] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         busy[i]   = (cnt_q[i] == CW'(FIFO_DEPTH));
         accept[i] = push[i] && (!busy[i] || pop[i]);
         wptr_d[i] = wptr_q[i] + PW'(accept[i]);
         rptr_d[i] = rptr_q[i] + PW'(pop[i]);
         cnt_d[i]  = cnt_q[i] + CW'(accept[i]) - CW'(pop[i]);
      end
      ovf_d = ovf_q | (|(push & ~accept));
      head  = mem_q[gnt_src][rptr_q[gnt_src]];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         ovf_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         wb_src_q   <= 2'd0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            wptr_q[i] <= wptr_d[i];
            rptr_q[i] <= rptr_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         ovf_q      <= ovf_d;
         wb_valid_q <= gnt_valid;
         if (gnt_valid) begin
            wb_rd_q   <= head.rd;
            wb_data_q <= head.data;
            wb_src_q  <= gnt_src;
         end
      end
   end

   // NOTE: entry storage is not reset; count and pointers decide validity, so stale data is never read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (accept[i]) begin
            mem_q[i][wptr_q[i]] <= in_entry[i];
         end
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign wb_src   = wb_src_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb_fu_wb_arbiter: directed self-checking bench for fu_wb_arbiter in its default
// configuration (FIFO_DEPTH=2, fixed priority).
module tb_fu_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  fin;
   logic [31:0] res0, res1, res2, res3;
   logic [4:0]  rd0, rd1, rd2, rd3;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [1:0]  wb_src;
   logic [3:0]  busy;
   logic        ovf;

   int vectors     = 0;
   int miscompares = 0;

   fu_wb_arbiter #(.FIFO_DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .fin      (fin),
      .res0     (res0),
      .res1     (res1),
      .res2     (res2),
      .res3     (res3),
      .rd0      (rd0),
      .rd1      (rd1),
      .rd2      (rd2),
      .rd3      (rd3),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .wb_src   (wb_src),
      .busy     (busy),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst  = 1'b1;
      fin  = 4'b0000;
      res0 = '0; res1 = '0; res2 = '0; res3 = '0;
      rd0  = '0; rd1  = '0; rd2  = '0; rd3  = '0;
      step();
      step();
      check("rst_valid", 64'(wb_valid), 64'd0);
      check("rst_rd",    64'(wb_rd),    64'd0);
      check("rst_data",  64'(wb_data),  64'd0);
      check("rst_src",   64'(wb_src),   64'd0);
      check("rst_busy",  64'(busy),     64'd0);
      check("rst_ovf",   64'(ovf),      64'd0);
      rst = 1'b0;
      step();

      // Single push on source 2: visible two edges later, then idle with held data.
      fin = 4'b0100; rd2 = 5'd5; res2 = 32'h1234_5678;
      step();
      fin = 4'b0000;
      check("single_nobypass", 64'(wb_valid), 64'd0);
      step();
      check("single_valid", 64'(wb_valid), 64'd1);
      check("single_rd",    64'(wb_rd),    64'd5);
      check("single_data",  64'(wb_data),  64'h1234_5678);
      check("single_src",   64'(wb_src),   64'd2);
      step();
      check("single_idle",  64'(wb_valid), 64'd0);
      check("single_hold",  64'(wb_data),  64'h1234_5678);
      check("single_hsrc",  64'(wb_src),   64'd2);

      // Lone grant to source 1 ahead of a four-way collision.
      fin = 4'b0010; rd1 = 5'd7; res1 = 32'h11;
      step();
      fin = 4'b0000;
      step();
      check("pre_src",  64'(wb_src),  64'd1);
      check("pre_data", 64'(wb_data), 64'h11);
      step();

      // All four sources finish together: drained 0,1,2,3 on consecutive cycles.
      fin = 4'b1111;
      rd0 = 5'd1; rd1 = 5'd2; rd2 = 5'd3; rd3 = 5'd4;
      res0 = 32'hA0; res1 = 32'hA1; res2 = 32'hA2; res3 = 32'hA3;
      step();
      fin = 4'b0000;
      check("coll_busy", 64'(busy), 64'd0);
      for (int s = 0; s < 4; s++) begin
         step();
         check("coll_valid", 64'(wb_valid), 64'd1);
         check("coll_src",   64'(wb_src),   64'(s));
         check("coll_rd",    64'(wb_rd),    64'(s + 1));
         check("coll_data",  64'(wb_data),  64'(32'hA0 + s));
      end
      step();
      check("coll_idle", 64'(wb_valid), 64'd0);

      // rd=0 result is discarded entirely.
      fin = 4'b0001; rd0 = 5'd0; res0 = 32'hDEAD;
      step();
      fin = 4'b0000;
      step();
      check("rd0_valid", 64'(wb_valid), 64'd0);
      check("rd0_ovf",   64'(ovf),      64'd0);
      step();
      check("rd0_valid2", 64'(wb_valid), 64'd0);

      // Source 0 keeps winning while source 3 fills and then overflows on its third push.
      rd0 = 5'd9; rd3 = 5'd10;
      for (int k = 0; k < 3; k++) begin
         fin  = 4'b1001;
         res0 = 32'h51 + 32'(k);
         res3 = 32'hA + 32'(k);
         step();
      end
      fin = 4'b0000;
      check("ovf_set",   64'(ovf),     64'd1);
      check("ovf_busy",  64'(busy),    64'b1000);
      check("ovf_wb2",   64'(wb_data), 64'h52);
      step();
      check("ovf_wb3",   64'(wb_data), 64'h53);
      check("ovf_src3",  64'(wb_src),  64'd0);
      // Push into the full queue on the same edge it is popped: accepted.
      fin = 4'b1000; res3 = 32'hD;
      step();
      fin = 4'b0000;
      check("ovf_a_data", 64'(wb_data), 64'hA);
      check("ovf_a_src",  64'(wb_src),  64'd3);
      check("ovf_a_busy", 64'(busy),    64'b1000);
      step();
      check("ovf_b_data", 64'(wb_data), 64'hB);
      check("ovf_b_busy", 64'(busy),    64'd0);
      step();
      check("ovf_d_data", 64'(wb_data), 64'hD);
      check("ovf_d_rd",   64'(wb_rd),   64'd10);
      step();
      check("ovf_idle",   64'(wb_valid), 64'd0);
      check("ovf_sticky", 64'(ovf),      64'd1);

      // Reset with entries queued and a same-edge push: everything flushed.
      fin = 4'b0111; rd0 = 5'd1; rd1 = 5'd2; rd2 = 5'd3;
      step();
      rst = 1'b1;
      fin = 4'b1000; rd3 = 5'd4; res3 = 32'h99;
      step();
      check("mrst_valid", 64'(wb_valid), 64'd0);
      check("mrst_busy",  64'(busy),     64'd0);
      check("mrst_ovf",   64'(ovf),      64'd0);
      check("mrst_data",  64'(wb_data),  64'd0);
      check("mrst_src",   64'(wb_src),   64'd0);
      rst = 1'b0;
      fin = 4'b0010; rd1 = 5'd3; res1 = 32'h77;
      step();
      fin = 4'b0000;
      check("post_flush", 64'(wb_valid), 64'd0);
      step();
      check("post_valid", 64'(wb_valid), 64'd1);
      check("post_src",   64'(wb_src),   64'd1);
      check("post_rd",    64'(wb_rd),    64'd3);
      check("post_data",  64'(wb_data),  64'h77);
      step();
      check("post_idle",  64'(wb_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
